// File: rtl/sram_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sram_scan_sequencer
// Description : Takes one command at a time and runs an SRAM scan-chain
//               transaction on a divided scan clock. A write shifts a word in
//               and then strobes chip select and load. A read also waits, then
//               shifts the chain back out and presents the captured word.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_scan_sequencer #(
  parameter int SCAN_LEN  = 112,
  parameter int CLK_DIV   = 2,
  parameter int LOAD_WAIT = 3
) (
  input  logic                wb_clk_i,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [SCAN_LEN-1:0] cmd_data,
  input  logic                cmd_capture,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SCAN_LEN-1:0] rsp_data,
  output logic                busy,
  output logic                scan_clk,
  output logic                scan_in,
  output logic                scan_en,
  output logic                sram_load,
  output logic                global_csb,
  input  logic                scan_out
);

  localparam int c_CW = $clog2(SCAN_LEN) + 1;
  localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(SCAN_LEN - 1);
  // LOAD_WAIT is expected to fit the bit counter; it shares that counter.
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'((LOAD_WAIT > 0) ? LOAD_WAIT - 1 : 0);
  localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(CLK_DIV - 1);
  localparam bit              c_SKIP_WAIT = (LOAD_WAIT == 0);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SHIFT_IN  = 3'd1;
  localparam logic [2:0] S_STROBE    = 3'd2;
  localparam logic [2:0] S_LOAD      = 3'd3;
  localparam logic [2:0] S_WAIT      = 3'd4;
  localparam logic [2:0] S_SHIFT_OUT = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [1:0]          r_rst_sync;
  logic [c_DW-1:0]     r_div;
  logic                r_phase;
  logic [c_CW-1:0]     r_bit;
  logic [SCAN_LEN-1:0] r_shift;
  logic [SCAN_LEN-1:0] r_rsp_data;
  logic                r_capture;
  logic                w_accept;
  logic                w_clk_run;
  logic                w_period_end;
  logic                w_bit_last;

  assign w_accept     = cmd_valid & cmd_ready;
  assign w_clk_run    = (r_state != S_IDLE) && (r_state != S_RESP);
  // Last cycle of the high phase: the only cycle on which state may advance,
  // so every registered change becomes visible on a period's first low cycle.
  assign w_period_end = w_clk_run && r_phase && (r_div == c_DIV_LAST);
  assign w_bit_last   = (r_bit == c_BIT_LAST);
  assign scan_clk     = r_phase;
  assign rsp_data     = r_rsp_data;

  // Reset release is synchronized; commands are refused until it propagates.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) r_rst_sync <= 2'b00;
    else         r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  // Scan clock divider: CLK_DIV cycles low then CLK_DIV cycles high, parked low when idle.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (!w_clk_run) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (r_div == c_DIV_LAST) begin
      r_div   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_div   <= r_div + c_DW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic; all running states advance only at period end.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_SHIFT_IN;
      S_SHIFT_IN:  if (w_period_end && w_bit_last) w_state_nxt = S_STROBE;
      S_STROBE:    if (w_period_end) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_period_end) begin
          if (!r_capture)       w_state_nxt = S_IDLE;
          else if (c_SKIP_WAIT) w_state_nxt = S_SHIFT_OUT;
          else                  w_state_nxt = S_WAIT;
        end
      end
      S_WAIT:      if (w_period_end && (r_bit == c_WAIT_LAST)) w_state_nxt = S_SHIFT_OUT;
      S_SHIFT_OUT: if (w_period_end && w_bit_last) w_state_nxt = S_RESP;
      S_RESP:      if (rsp_ready) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: harness strobes decoded from state alone.
  always_comb begin
    scan_en    = 1'b0;
    scan_in    = 1'b0;
    sram_load  = 1'b0;
    global_csb = 1'b1;
    rsp_valid  = 1'b0;
    busy       = (r_state != S_IDLE);
    // Ready is shown during reset but withheld until the release is synchronized.
    cmd_ready  = (r_state == S_IDLE) && (r_rst_sync[1] || !resetn);
    case (r_state)
      S_SHIFT_IN: begin
        scan_en = 1'b1;
        scan_in = r_shift[SCAN_LEN-1];
      end
      S_STROBE:    global_csb = 1'b0;
      S_LOAD:      sram_load  = 1'b1;
      S_SHIFT_OUT: scan_en    = 1'b1;
      S_RESP:      rsp_valid  = 1'b1;
      default:     ;
    endcase
  end

  // Period counter within a state; cleared on every state change so it never wraps.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn)                        r_bit <= '0;
    else if (w_state_nxt != r_state)    r_bit <= '0;
    else if (w_period_end)              r_bit <= r_bit + c_CW'(1);
  end

  // Shift register: unloads the command MSB first, then collects scan_out.
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      r_shift    <= '0;
      r_capture  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_shift   <= cmd_data;
        r_capture <= cmd_capture;
      end else if (w_period_end && (r_state == S_SHIFT_IN)) begin
        r_shift   <= {r_shift[SCAN_LEN-2:0], 1'b0};
      end else if (w_period_end && (r_state == S_SHIFT_OUT)) begin
        r_shift   <= {r_shift[SCAN_LEN-2:0], scan_out};
      end
      // The response word is updated only once, on the final sample.
      if (w_period_end && (r_state == S_SHIFT_OUT) && w_bit_last)
        r_rsp_data <= {r_shift[SCAN_LEN-2:0], scan_out};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_scan_sequencer
// Description : Directed bench for sram_scan_sequencer with a scan-chain
//               harness model; a second instance runs the fast divider with
//               no wait periods.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_scan_sequencer;

  localparam int SCAN_LEN = 112;
  localparam logic [SCAN_LEN-1:0] c_PAT   = {14{8'h5A}};
  localparam logic [SCAN_LEN-1:0] c_WRITE = {4'hA, 16'd1, 32'd1, 1'b0, 1'b0, 4'hF,
                                             16'd0, 32'd0, 1'b1, 1'b1, 4'h0};

  logic clk = 1'b0;
  logic resetn;

  logic                cmd_valid, cmd_ready, cmd_capture;
  logic [SCAN_LEN-1:0] cmd_data;
  logic                rsp_valid, rsp_ready;
  logic [SCAN_LEN-1:0] rsp_data;
  logic                busy, scan_clk, scan_in, scan_en, sram_load, global_csb, scan_out;

  logic                cmd_valid_2, cmd_ready_2, cmd_capture_2;
  logic [SCAN_LEN-1:0] cmd_data_2;
  logic                rsp_valid_2, rsp_ready_2;
  logic [SCAN_LEN-1:0] rsp_data_2;
  logic                busy_2, scan_clk_2, scan_in_2, scan_en_2, sram_load_2, global_csb_2;
  logic                scan_out_2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sram_scan_sequencer #(.SCAN_LEN(SCAN_LEN), .CLK_DIV(2), .LOAD_WAIT(3)) u_dut (
    .wb_clk_i(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_capture(cmd_capture), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy), .scan_clk(scan_clk), .scan_in(scan_in),
    .scan_en(scan_en), .sram_load(sram_load), .global_csb(global_csb),
    .scan_out(scan_out)
  );

  sram_scan_sequencer #(.SCAN_LEN(SCAN_LEN), .CLK_DIV(1), .LOAD_WAIT(0)) u_dut_fast (
    .wb_clk_i(clk), .resetn(resetn),
    .cmd_valid(cmd_valid_2), .cmd_ready(cmd_ready_2), .cmd_data(cmd_data_2),
    .cmd_capture(cmd_capture_2), .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready_2),
    .rsp_data(rsp_data_2), .busy(busy_2), .scan_clk(scan_clk_2), .scan_in(scan_in_2),
    .scan_en(scan_en_2), .sram_load(sram_load_2), .global_csb(global_csb_2),
    .scan_out(scan_out_2)
  );

  assign scan_out_2 = 1'b1;

  // Harness chain: captures on scan_clk rise, shifts on fall, reloads the
  // fixed pattern on load (keeping a copy of what was written).
  logic [SCAN_LEN-1:0] h_chain   = '0;
  logic [SCAN_LEN-1:0] h_written = '0;
  logic                h_en      = 1'b0;
  logic                h_din     = 1'b0;
  assign scan_out = h_chain[SCAN_LEN-1];

  always @(scan_clk) begin
    if (scan_clk === 1'b1) begin
      h_en  <= scan_en;
      h_din <= scan_in;
      if (sram_load) begin
        h_written <= h_chain;
        h_chain   <= c_PAT;
      end
    end else if (h_en) begin
      h_chain <= {h_chain[SCAN_LEN-2:0], h_din};
    end
  end

  // Cycle counters for strobe widths.
  int unsigned mon_csb = 0, mon_load = 0, mon_rsp = 0;
  always @(negedge clk) begin
    if (global_csb === 1'b0) mon_csb++;
    if (sram_load === 1'b1)  mon_load++;
    if (rsp_valid === 1'b1)  mon_rsp++;
  end

  // Present a command and return on the negedge of the first cycle after accept.
  task automatic do_cmd(input logic [SCAN_LEN-1:0] d, input logic cap);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = d; cmd_capture = cap;
    while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
    else passes++;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    cmd_valid = 0; cmd_data = '0; cmd_capture = 0; rsp_ready = 0;
    cmd_valid_2 = 0; cmd_data_2 = '0; cmd_capture_2 = 0; rsp_ready_2 = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, busy, scan_clk, scan_in, scan_en, sram_load, global_csb} !== 8'b1000_0001)
      $display("FAIL reset_outputs: got %b required 10000001",
               {cmd_ready, rsp_valid, busy, scan_clk, scan_in, scan_en, sram_load, global_csb});
    else passes++;
    checks++;
    if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h required 0", rsp_data);
    else passes++;
    resetn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write;
    int n = 0;
    int unsigned csb0 = mon_csb, load0 = mon_load, rsp0 = mon_rsp;
    do_cmd(c_WRITE, 1'b0);
    checks++;
    if ({busy, cmd_ready, scan_en} !== 3'b101)
      $display("FAIL write_start: busy/ready/en=%b required 101", {busy, cmd_ready, scan_en});
    else passes++;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 456) $display("FAIL write_busy_cycles: got %0d required 456", n);
    else passes++;
    @(negedge clk);
    checks++;
    if (h_written !== c_WRITE) $display("FAIL write_bits: got %h required %h", h_written, c_WRITE);
    else passes++;
    checks++;
    if (mon_csb - csb0 !== 4) $display("FAIL write_csb_low: got %0d required 4", mon_csb - csb0);
    else passes++;
    checks++;
    if (mon_load - load0 !== 4) $display("FAIL write_load_high: got %0d required 4", mon_load - load0);
    else passes++;
    checks++;
    if (mon_rsp - rsp0 !== 0) $display("FAIL write_no_rsp: got %0d required 0", mon_rsp - rsp0);
    else passes++;
  endtask

  task automatic test_read_stall;
    int n = 0;
    int bad = 0;
    rsp_ready = 1'b0;
    do_cmd({14{8'hC3}}, 1'b1);
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 916) $display("FAIL read_latency: got %0d required 916", n);
    else passes++;
    checks++;
    if (rsp_data !== c_PAT) $display("FAIL read_data: got %h required %h", rsp_data, c_PAT);
    else passes++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== c_PAT || scan_clk !== 1'b0 || cmd_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL resp_stall: %0d bad cycles required 0", bad);
    else passes++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001)
      $display("FAIL resp_exit: valid/busy/ready=%b required 001", {rsp_valid, busy, cmd_ready});
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if (rsp_data !== c_PAT) $display("FAIL rsp_retain: got %h required %h", rsp_data, c_PAT);
    else passes++;
  endtask

  task automatic test_reset_mid_shift;
    int n = 0;
    int bad = 0;
    do_cmd(c_WRITE, 1'b1);
    repeat (240) @(negedge clk);
    checks++;
    if (scan_en !== 1'b1) $display("FAIL mid_shift_state: scan_en=%b required 1", scan_en);
    else passes++;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, busy, scan_clk, scan_in, scan_en, sram_load, global_csb} !== 8'b1000_0001 ||
        rsp_data !== '0)
      $display("FAIL async_reset: got %b data %h required 10000001 data 0",
               {cmd_ready, rsp_valid, busy, scan_clk, scan_in, scan_en, sram_load, global_csb}, rsp_data);
    else passes++;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || rsp_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL abandon: %0d bad cycles required 0", bad);
    else passes++;
    rsp_ready = 1'b1;
    do_cmd(c_WRITE, 1'b1);
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 916 || rsp_data !== c_PAT)
      $display("FAIL post_reset_read: latency %0d data %h required 916 data %h", n, rsp_data, c_PAT);
    else passes++;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01)
      $display("FAIL resp_one_cycle: valid/ready=%b required 01", {rsp_valid, cmd_ready});
    else passes++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n = 0;
    @(negedge clk);
    cmd_valid_2 = 1'b1; cmd_data_2 = c_PAT; cmd_capture_2 = 1'b1;
    while (!cmd_ready_2 && n < 1000) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid_2 = 1'b0;
    n = 0;
    while (!rsp_valid_2 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 452) $display("FAIL fast_latency: got %0d required 452", n);
    else passes++;
    checks++;
    if (rsp_data_2 !== {SCAN_LEN{1'b1}})
      $display("FAIL fast_data: got %h required all ones", rsp_data_2);
    else passes++;
    cmd_valid_2 = 1'b1; cmd_data_2 = c_WRITE; cmd_capture_2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid_2, cmd_ready_2} !== 2'b10)
      $display("FAIL b2b_stall: valid/ready=%b required 10", {rsp_valid_2, cmd_ready_2});
    else passes++;
    rsp_ready_2 = 1'b1;
    @(negedge clk);
    rsp_ready_2 = 1'b0;
    checks++;
    if ({rsp_valid_2, busy_2, cmd_ready_2} !== 3'b001)
      $display("FAIL b2b_first_idle: valid/busy/ready=%b required 001", {rsp_valid_2, busy_2, cmd_ready_2});
    else passes++;
    @(negedge clk);
    cmd_valid_2 = 1'b0;
    checks++;
    if ({busy_2, cmd_ready_2, scan_en_2} !== 3'b101)
      $display("FAIL b2b_accept: busy/ready/en=%b required 101", {busy_2, cmd_ready_2, scan_en_2});
    else passes++;
    n = 0;
    while (busy_2 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 228 || rsp_valid_2 !== 1'b0)
      $display("FAIL b2b_write_len: got %0d valid %b required 228 valid 0", n, rsp_valid_2);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_reset_mid_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
